// File: rtl/nn_pkg.sv
// Shared definitions for the training sequencer: state encoding and width helper.
package nn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_LOAD = 3'd2,
        ST_FWD  = 3'd3,
        ST_BWD  = 3'd4,
        ST_UPD  = 3'd5,
        ST_DONE = 3'd6
    } nn_state_e;

    // Bits needed to index n items, never less than one.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/nn_phase_timer.sv
// Loadable down-counter with a registered terminal-count flag. Loaded with
// (duration-1) on entry to a timed phase; tc is high in the last cycle.
module nn_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;

    // Next count: load wins, otherwise decrement and stop at zero.
    always_comb begin
        count_next_s = count_r;
        if (load) begin
            count_next_s = load_val;
        end else if (dec && (count_r != CNT_ZERO)) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register and terminal-count flag aligned with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= CNT_ZERO;
            tc      <= 1'b1;
        end else begin
            count_r <= count_next_s;
            tc      <= (count_next_s == CNT_ZERO);
        end
    end

endmodule

// File: rtl/nn_train_ctrl.sv
// Training sequencer: drives parameter-register init/update strobes and steps
// the forward/backward passes over the sample set for N_EPOCHS epochs, or runs
// a single forward-only inference pass.
module nn_train_ctrl
    import nn_pkg::*;
#(
    parameter int N_SAMPLES = 4,
    parameter int N_EPOCHS  = 1000,
    parameter int FWD_LAT   = 3,
    parameter int BWD_LAT   = 4,
    parameter int EPOCH_W   = 16,
    parameter int IDX_W     = idx_width(N_SAMPLES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               infer,
    input  logic [IDX_W-1:0]   infer_idx,
    input  logic               abort,
    output logic               select_initial,
    output logic               select_update,
    output logic               sample_load,
    output logic [IDX_W-1:0]   sample_idx,
    output logic               fwd_en,
    output logic               bwd_en,
    output logic               busy,
    output logic               done,
    output logic [EPOCH_W-1:0] epoch
);

    localparam int CNT_W = idx_width((FWD_LAT > BWD_LAT) ? FWD_LAT : BWD_LAT);

    localparam logic [IDX_W-1:0]   IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0] EPOCH_ZERO = {EPOCH_W{1'b0}};
    localparam logic [EPOCH_W-1:0] EPOCH_ONE  = EPOCH_W'(1);
    localparam logic [EPOCH_W-1:0] EPOCH_MAX  = {EPOCH_W{1'b1}};
    localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(N_EPOCHS);
    localparam logic [CNT_W-1:0]   FWD_LOAD   = CNT_W'(FWD_LAT - 1);
    localparam logic [CNT_W-1:0]   BWD_LOAD   = CNT_W'(BWD_LAT - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};

    nn_state_e          state_r;
    nn_state_e          state_next_s;
    logic               infer_mode_r;
    logic               infer_mode_next_s;
    logic [IDX_W-1:0]   idx_next_s;
    logic [EPOCH_W-1:0] epoch_next_s;
    logic [EPOCH_W-1:0] epoch_inc_s;
    logic               timer_load_s;
    logic               timer_dec_s;
    logic [CNT_W-1:0]   timer_val_s;
    logic               timer_tc_s;

    nn_phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load_s),
        .dec      (timer_dec_s),
        .load_val (timer_val_s),
        .tc       (timer_tc_s)
    );

    // Next state, sample index, epoch count and timer control.
    always_comb begin
        state_next_s      = state_r;
        infer_mode_next_s = infer_mode_r;
        idx_next_s        = sample_idx;
        epoch_next_s      = epoch;
        timer_load_s      = 1'b0;
        timer_dec_s       = 1'b0;
        timer_val_s       = CNT_ZERO;
        if (epoch == EPOCH_MAX) begin
            epoch_inc_s = epoch;
        end else begin
            epoch_inc_s = epoch + EPOCH_ONE;
        end

        if (abort) begin
            // Abort drops straight to IDLE; the epoch count is kept.
            state_next_s      = ST_IDLE;
            infer_mode_next_s = 1'b0;
            idx_next_s        = IDX_ZERO;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_next_s      = ST_INIT;
                        infer_mode_next_s = 1'b0;
                        idx_next_s        = IDX_ZERO;
                        epoch_next_s      = EPOCH_ZERO;
                    end else if (infer) begin
                        state_next_s      = ST_LOAD;
                        infer_mode_next_s = 1'b1;
                        idx_next_s        = infer_idx;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_INIT: begin
                    state_next_s = ST_LOAD;
                end
                ST_LOAD: begin
                    state_next_s = ST_FWD;
                    timer_load_s = 1'b1;
                    timer_val_s  = FWD_LOAD;
                end
                ST_FWD: begin
                    if (!timer_tc_s) begin
                        timer_dec_s = 1'b1;
                    end else if (infer_mode_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_BWD;
                        timer_load_s = 1'b1;
                        timer_val_s  = BWD_LOAD;
                    end
                end
                ST_BWD: begin
                    if (timer_tc_s) begin
                        state_next_s = ST_UPD;
                    end else begin
                        timer_dec_s = 1'b1;
                    end
                end
                ST_UPD: begin
                    if (sample_idx < IDX_LAST) begin
                        idx_next_s   = sample_idx + IDX_ONE;
                        state_next_s = ST_LOAD;
                    end else begin
                        idx_next_s   = IDX_ZERO;
                        epoch_next_s = epoch_inc_s;
                        if (epoch_inc_s == EPOCH_LAST) begin
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_LOAD;
                        end
                    end
                end
                default: begin
                    state_next_s      = ST_IDLE;
                    infer_mode_next_s = 1'b0;
                    idx_next_s        = IDX_ZERO;
                end
            endcase
        end
    end

    // State register plus outputs decoded from the next state, so each strobe
    // lines up exactly with the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            infer_mode_r   <= 1'b0;
            sample_idx     <= IDX_ZERO;
            epoch          <= EPOCH_ZERO;
            select_initial <= 1'b0;
            select_update  <= 1'b0;
            sample_load    <= 1'b0;
            fwd_en         <= 1'b0;
            bwd_en         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            infer_mode_r   <= infer_mode_next_s;
            sample_idx     <= idx_next_s;
            epoch          <= epoch_next_s;
            select_initial <= (state_next_s == ST_INIT);
            select_update  <= (state_next_s == ST_UPD);
            sample_load    <= (state_next_s == ST_LOAD);
            fwd_en         <= (state_next_s == ST_FWD);
            bwd_en         <= (state_next_s == ST_BWD);
            busy           <= (state_next_s != ST_IDLE) && (state_next_s != ST_DONE);
            done           <= (state_next_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_nn_train_ctrl.sv
// Self-checking bench for nn_train_ctrl. The reference model tracks a run as
// "cycles since the start edge" and derives every output arithmetically.
module tb_nn_train_ctrl;

    localparam int NS      = 4;
    localparam int NE      = 2;
    localparam int FL      = 3;
    localparam int BL      = 4;
    localparam int EW      = 16;
    localparam int IW      = 2;
    localparam int SPS     = 2 + FL + BL;
    localparam int RUN_LEN = 1 + NE * NS * SPS;
    localparam int VW      = 7 + IW + EW;

    localparam int M_IDLE  = 0;
    localparam int M_TRAIN = 1;
    localparam int M_INFER = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          reset, start, infer, abort;
    logic [IW-1:0] infer_idx;
    logic          select_initial, select_update, sample_load, fwd_en, bwd_en, busy, done;
    logic [IW-1:0] sample_idx;
    logic [EW-1:0] epoch;
    logic [VW-1:0] dut_vec;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int m_mode, m_t, m_epoch, m_idx;

    always #5 clk = ~clk;

    nn_train_ctrl #(
        .N_SAMPLES (NS),
        .N_EPOCHS  (NE),
        .FWD_LAT   (FL),
        .BWD_LAT   (BL),
        .EPOCH_W   (EW),
        .IDX_W     (IW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .infer          (infer),
        .infer_idx      (infer_idx),
        .abort          (abort),
        .select_initial (select_initial),
        .select_update  (select_update),
        .sample_load    (sample_load),
        .sample_idx     (sample_idx),
        .fwd_en         (fwd_en),
        .bwd_en         (bwd_en),
        .busy           (busy),
        .done           (done),
        .epoch          (epoch)
    );

    assign dut_vec = {select_initial, select_update, sample_load, fwd_en, bwd_en,
                      busy, done, sample_idx, epoch};

    // Completed epochs as seen by the model right now.
    function automatic int cur_epoch();
        if (m_mode == M_TRAIN) begin
            if (m_t == 0) return 0;
            return ((m_t - 1) / SPS) / NS;
        end
        return m_epoch;
    endfunction

    // Expected output vector from the model state.
    function automatic logic [VW-1:0] exp_vec();
        logic si, su, sl, fe, be, bz, dn;
        int idx, ep, u, k;
        si = 1'b0; su = 1'b0; sl = 1'b0; fe = 1'b0; be = 1'b0; bz = 1'b0; dn = 1'b0;
        idx = 0;
        ep  = cur_epoch();
        case (m_mode)
            M_TRAIN: begin
                bz = 1'b1;
                if (m_t == 0) begin
                    si = 1'b1;
                end else begin
                    u   = m_t - 1;
                    k   = u % SPS;
                    idx = (u / SPS) % NS;
                    sl  = (k == 0);
                    fe  = (k >= 1) && (k <= FL);
                    be  = (k > FL) && (k <= FL + BL);
                    su  = (k == SPS - 1);
                end
            end
            M_INFER: begin
                bz  = 1'b1;
                idx = m_idx;
                sl  = (m_t == 0);
                fe  = (m_t >= 1);
            end
            M_DONE: begin
                dn  = 1'b1;
                idx = m_idx;
            end
            default: idx = 0;
        endcase
        return {si, su, sl, fe, be, bz, dn, IW'(idx), EW'(ep)};
    endfunction

    // Advance the model across one clock edge with the given inputs.
    task automatic model_step(input logic rs, input logic s, input logic i,
                              input logic ab, input int ix);
        if (rs) begin
            m_mode = M_IDLE; m_t = 0; m_epoch = 0; m_idx = 0;
        end else if (ab) begin
            m_epoch = cur_epoch(); m_mode = M_IDLE; m_idx = 0;
        end else begin
            case (m_mode)
                M_TRAIN: begin
                    m_t++;
                    if (m_t == RUN_LEN) begin
                        m_mode = M_DONE; m_epoch = NE; m_idx = 0;
                    end
                end
                M_INFER: begin
                    m_t++;
                    if (m_t == 1 + FL) m_mode = M_DONE;
                end
                default: begin
                    if (s) begin
                        m_mode = M_TRAIN; m_t = 0; m_epoch = 0; m_idx = 0;
                    end else if (i) begin
                        m_mode = M_INFER; m_t = 0; m_idx = ix;
                    end
                end
            endcase
        end
    endtask

    // Apply inputs for one edge, step the model, sample 1 time unit after the edge.
    task automatic drive(input logic rs, input logic s, input logic i,
                         input logic ab, input logic [IW-1:0] ix);
        reset = rs; start = s; infer = i; abort = ab; infer_idx = ix;
        model_step(rs, s, i, ab, int'(ix));
        @(posedge clk);
        #1;
        cyc_n++;
        reset = 1'b0; start = 1'b0; infer = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, IW'(0));
            total++;
            if (dut_vec !== {VW{1'b0}}) begin
                bad++;
                $display("FAIL reset_state cyc=%0d got=%h want=%h", cyc_n, dut_vec, {VW{1'b0}});
            end
        end
    endtask

    task automatic test_train(input bit poke_start);
        int su_n, si_n, done_at;
        su_n = 0; si_n = 0; done_at = -1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, IW'(0));
        total++;
        if (dut_vec !== exp_vec() || select_initial !== 1'b1 || done !== 1'b0 || epoch !== EW'(0)) begin
            bad++;
            $display("FAIL train_start cyc=%0d got=%h want=%h", cyc_n, dut_vec, exp_vec());
        end
        if (select_initial === 1'b1) si_n++;
        for (int j = 1; j <= RUN_LEN + 20 && done_at < 0; j++) begin
            drive(1'b0, poke_start && ($urandom_range(0, 5) == 0), 1'b0, 1'b0, IW'($urandom));
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL train_cycle cyc=%0d got=%h want=%h", cyc_n, dut_vec, exp_vec());
            end
            if (select_update === 1'b1) su_n++;
            if (select_initial === 1'b1) si_n++;
            if (done === 1'b1) done_at = j;
        end
        total++;
        if (done_at != RUN_LEN) begin
            bad++;
            $display("FAIL train_done_latency got=%0d want=%0d", done_at, RUN_LEN);
        end
        total++;
        if (su_n != NE * NS || si_n != 1) begin
            bad++;
            $display("FAIL train_pulse_counts update=%0d init=%0d want %0d/1", su_n, si_n, NE * NS);
        end
        total++;
        if (epoch !== EW'(NE) || busy !== 1'b0) begin
            bad++;
            $display("FAIL train_final_epoch got=%0d busy=%b want=%0d busy=0", epoch, busy, NE);
        end
    endtask

    task automatic test_infer();
        int fwd_n, stray_n, done_at;
        fwd_n = 0; stray_n = 0; done_at = -1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, IW'(0));
        drive(1'b0, 1'b0, 1'b1, 1'b0, IW'(2));
        total++;
        if (dut_vec !== exp_vec() || sample_load !== 1'b1 || sample_idx !== IW'(2)) begin
            bad++;
            $display("FAIL infer_load cyc=%0d got=%h want=%h", cyc_n, dut_vec, exp_vec());
        end
        for (int j = 1; j <= 20 && done_at < 0; j++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, IW'(0));
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL infer_cycle cyc=%0d got=%h want=%h", cyc_n, dut_vec, exp_vec());
            end
            if (fwd_en === 1'b1) fwd_n++;
            if (bwd_en === 1'b1 || select_update === 1'b1 || select_initial === 1'b1) stray_n++;
            if (done === 1'b1) done_at = j;
        end
        total++;
        if (fwd_n != FL || stray_n != 0 || done_at != FL + 1 || epoch !== EW'(NE)) begin
            bad++;
            $display("FAIL infer_shape fwd=%0d stray=%0d done_at=%0d epoch=%0d want %0d/0/%0d/%0d",
                     fwd_n, stray_n, done_at, epoch, FL, FL + 1, NE);
        end
    endtask

    task automatic test_abort();
        int su_n;
        su_n = 0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, IW'(0));
        for (int j = 1; j <= 1 + SPS + FL + 1 + 1; j++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, IW'(0));
            if (select_update === 1'b1) su_n++;
        end
        total++;
        if (bwd_en !== 1'b1 || sample_idx !== IW'(1) || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL abort_setup cyc=%0d got=%h want=%h", cyc_n, dut_vec, exp_vec());
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, IW'(0));
        total++;
        if (dut_vec !== {VW{1'b0}} || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL abort_idle cyc=%0d got=%h want=%h", cyc_n, dut_vec, exp_vec());
        end
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, IW'(0));
            if (select_update === 1'b1) su_n++;
        end
        total++;
        if (su_n != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_update updates=%0d busy=%b want 1/0", su_n, busy);
        end
    endtask

    task automatic test_collide();
        drive(1'b0, 1'b1, 1'b0, 1'b1, IW'(0));
        total++;
        if (busy !== 1'b0 || select_initial !== 1'b0 || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL start_abort_same cyc=%0d got=%h want=%h", cyc_n, dut_vec, exp_vec());
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, IW'(3));
        total++;
        if (select_initial !== 1'b1 || sample_load !== 1'b0 || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL start_over_infer cyc=%0d got=%h want=%h", cyc_n, dut_vec, exp_vec());
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, IW'(0));
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b0, 1'b0, IW'(0));
        for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, 1'b0, 1'b0, IW'(0));
        total++;
        if (fwd_en !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_setup fwd_en got=%b want=1", fwd_en);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, IW'(0));
        total++;
        if (dut_vec !== {VW{1'b0}}) begin
            bad++;
            $display("FAIL reset_mid_clear got=%h want=%h", dut_vec, {VW{1'b0}});
        end
        test_train(1'b0);
    endtask

    task automatic test_random();
        logic prev_su, s, i, ab, rs;
        int r;
        prev_su = 1'b0;
        for (int j = 0; j < 1500; j++) begin
            r  = $urandom_range(0, 199);
            rs = (r == 0);
            ab = (r >= 1 && r <= 3);
            s  = (r >= 4 && r <= 11);
            i  = (r >= 8 && r <= 17);
            drive(rs, s, i, ab, IW'($urandom));
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random_cycle cyc=%0d got=%h want=%h", cyc_n, dut_vec, exp_vec());
            end
            total++;
            if ((select_initial & select_update) || (prev_su & select_update) ||
                (int'(fwd_en) + int'(bwd_en) + int'(sample_load) > 1)) begin
                bad++;
                $display("FAIL random_invariant cyc=%0d got=%h want=exclusive strobes", cyc_n, dut_vec);
            end
            prev_su = select_update;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; infer = 1'b0; abort = 1'b0; infer_idx = '0;
        m_mode = M_IDLE; m_t = 0; m_epoch = 0; m_idx = 0;
        test_reset();
        test_train(1'b0);
        test_train(1'b1);
        test_infer();
        test_abort();
        test_collide();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
